// File: rtl/memcmd_pkg.sv
// Shared types for the DDR command decoder: decoded command codes,
// power states, raw ras/cas/we pin patterns and the strobe bundle.
package memcmd_pkg;

  typedef enum logic [3:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_RDA, CMD_WR, CMD_WRA, CMD_PR, CMD_PRA,
    CMD_REF, CMD_MRW, CMD_MRR, CMD_BST, CMD_CFG, CMD_RSV
  } cmd_e;

  typedef enum logic [2:0] {
    PWR_INIT, PWR_ACTIVE, PWR_PWRDN, PWR_SELFREF, PWR_DEEPPD
  } pwr_state_e;

  // {ras_n, cas_n, we_n} encodings
  localparam logic [2:0] RCW_MRW = 3'b000;
  localparam logic [2:0] RCW_REF = 3'b001;
  localparam logic [2:0] RCW_PR  = 3'b010;
  localparam logic [2:0] RCW_RSV = 3'b011;
  localparam logic [2:0] RCW_WR  = 3'b100;
  localparam logic [2:0] RCW_RD  = 3'b101;
  localparam logic [2:0] RCW_BST = 3'b110;
  localparam logic [2:0] RCW_NOP = 3'b111;

  // One bit per output strobe
  typedef struct packed {
    logic act, rd, rda, wr, wra, pr, pra, refr, srf, pd, pdx;
    logic dpd, dpdx, mrw, mrr, bst, cfg, ckeh, ckel;
  } strobe_t;

  // Strobe pattern for a command forwarded while ACTIVE
  function automatic strobe_t cmd_strobe(input cmd_e cmd);
    strobe_t s;
    s = '0;
    case (cmd)
      CMD_ACT: s.act  = 1'b1;
      CMD_RD:  s.rd   = 1'b1;
      CMD_RDA: s.rda  = 1'b1;
      CMD_WR:  s.wr   = 1'b1;
      CMD_WRA: s.wra  = 1'b1;
      CMD_PR:  s.pr   = 1'b1;
      CMD_PRA: s.pra  = 1'b1;
      CMD_REF: s.refr = 1'b1;
      CMD_MRW: s.mrw  = 1'b1;
      CMD_MRR: s.mrr  = 1'b1;
      CMD_BST: s.bst  = 1'b1;
      CMD_CFG: s.cfg  = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  // Commands that target a single bank
  function automatic logic is_banked(input cmd_e cmd);
    return cmd inside {CMD_ACT, CMD_RD, CMD_RDA, CMD_WR, CMD_WRA, CMD_PR, CMD_BST};
  endfunction

endpackage

// File: rtl/memcmd_if.sv
// DDR command pins in, decoded strobes and bank status out.
interface memcmd_if #(
  parameter int NBG   = 2,
  parameter int NBA   = 4,
  parameter int ADDRW = 17
);
  localparam int NBANK = NBG * NBA;
  localparam int BIDX  = $clog2(NBANK);

  logic                     cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [ADDRW-1:0]         a;
  logic [$clog2(NBG)-1:0]   bg;
  logic [$clog2(NBA)-1:0]   ba;

  logic ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX;
  logic DPD, DPDX, MRW, MRR, BST, CFG, CKEH, CKEL;
  logic [NBANK-1:0]         bank_sel;
  logic [BIDX-1:0]          bank_idx;
  logic [ADDRW-1:0]         row_addr;
  logic [9:0]               col_addr;
  logic [NBANK-1:0]         bank_open;
  logic                     cmd_err;

  modport master (
    output cke, cs_n, act_n, ras_n, cas_n, we_n, a, bg, ba,
    input  ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX,
           DPD, DPDX, MRW, MRR, BST, CFG, CKEH, CKEL,
           bank_sel, bank_idx, row_addr, col_addr, bank_open, cmd_err
  );

  modport slave (
    input  cke, cs_n, act_n, ras_n, cas_n, we_n, a, bg, ba,
    output ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX,
           DPD, DPDX, MRW, MRR, BST, CFG, CKEH, CKEL,
           bank_sel, bank_idx, row_addr, col_addr, bank_open, cmd_err
  );
endinterface

// File: rtl/memcmd_bank_tracker.sv
// Per-bank open/closed tracking, command legality against that status,
// and the target mask that accompanies every strobe.
module memcmd_bank_tracker
  import memcmd_pkg::*;
#(
  parameter int NBANK = 8,
  parameter int BIDX  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cmd_e             i_cmd,        // command offered for forwarding (NOP if none)
  input  logic [BIDX-1:0]  i_idx,
  input  logic             i_all_sel,    // power event: drive all-ones mask
  input  logic             i_clear_all,  // deep power-down exit wipes status
  output logic             o_legal,
  output logic             o_any_open,
  output logic [NBANK-1:0] o_bank_sel,
  output logic [NBANK-1:0] o_bank_open
);

  logic [NBANK-1:0] r_bank_open;
  logic [NBANK-1:0] w_open_nxt;
  logic [NBANK-1:0] w_onehot;
  logic             w_hit;
  logic             w_any_open;
  logic             w_legal;

  assign w_onehot    = {{(NBANK-1){1'b0}}, 1'b1} << i_idx;
  assign w_hit       = r_bank_open[i_idx];
  assign w_any_open  = |r_bank_open;
  assign o_legal     = w_legal;
  assign o_any_open  = w_any_open;
  assign o_bank_open = r_bank_open;

  // Legality of the offered command against current bank status
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_legal = 1'b1;
    case (i_cmd)
      CMD_ACT:                                 w_legal = !w_hit;
      CMD_RD, CMD_RDA, CMD_WR, CMD_WRA, CMD_BST: w_legal = w_hit;
      CMD_REF, CMD_MRW, CMD_CFG:               w_legal = !w_any_open;
      CMD_RSV:                                 w_legal = 1'b0;
      default: ;
    endcase
  end

  // Target mask: one-hot for banked commands, all ones for global ones
  always_comb begin
    o_bank_sel = '0;
    if (i_all_sel) begin
      o_bank_sel = '1;
    end else if (w_legal) begin
      if (is_banked(i_cmd))
        o_bank_sel = w_onehot;
      else if (i_cmd inside {CMD_PRA, CMD_REF, CMD_MRW, CMD_MRR, CMD_CFG})
        o_bank_sel = '1;
    end
  end

  // Next open-row status from legal ACT/PR/PRA/auto-precharge
  always_comb begin
    w_open_nxt = r_bank_open;
    if (i_clear_all) begin
      w_open_nxt = '0;
    end else if (w_legal) begin
      case (i_cmd)
        CMD_ACT:                 w_open_nxt[i_idx] = 1'b1;
        CMD_PR, CMD_RDA, CMD_WRA: w_open_nxt[i_idx] = 1'b0;
        CMD_PRA:                 w_open_nxt = '0;
        default: ;
      endcase
    end
  end

  // Open-row status register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: bank_open is a small flop vector rather than a RAM, so it takes the async reset like any other state.
    if (!rst_n) r_bank_open <= '0;
    else        r_bank_open <= w_open_nxt;
  end

endmodule

// File: rtl/memcmd_decode.sv
// DDR command decoder: pin decode, CKE power FSM and the single output
// register stage feeding the per-bank timing FSMs.
module memcmd_decode
  import memcmd_pkg::*;
#(
  parameter int NBG   = 2,
  parameter int NBA   = 4,
  parameter int ADDRW = 17
) (
  input  logic     clk,
  input  logic     rst_n,
  memcmd_if.slave  bus
);

  localparam int NBANK = NBG * NBA;
  localparam int BIDX  = $clog2(NBANK);

  pwr_state_e       r_state, w_state_nxt;
  logic             r_cke_q;
  cmd_e             w_cmd, w_trk_cmd;
  logic [2:0]       w_rcw;
  logic [BIDX-1:0]  w_idx;
  logic             w_rise, w_fwd;
  strobe_t          w_strb, r_strb;
  logic             w_err, r_err;
  logic             w_all_sel, w_clear_all;
  logic             w_legal, w_any_open;
  logic [NBANK-1:0] w_bank_sel, r_bank_sel, w_bank_open;
  logic [BIDX-1:0]  r_bank_idx;
  logic [ADDRW-1:0] r_row_addr;
  logic [9:0]       r_col_addr;

  assign w_rcw  = {bus.ras_n, bus.cas_n, bus.we_n};
  assign w_idx  = {bus.bg, bus.ba};
  assign w_rise = bus.cke & ~r_cke_q;

  // Commands only reach the bank tracker while ACTIVE with cke held high
  assign w_trk_cmd = (r_state == PWR_ACTIVE && bus.cke) ? w_cmd : CMD_NOP;
  assign w_fwd     = (w_trk_cmd != CMD_NOP) && w_legal;

  // Raw pin decode
  always_comb begin
    w_cmd = CMD_NOP;
    if (!bus.cs_n) begin
      if (!bus.act_n) begin
        w_cmd = CMD_ACT;
      end else begin
        case (w_rcw)
          RCW_MRW: w_cmd = bus.a[13] ? CMD_MRR : CMD_MRW;
          RCW_REF: w_cmd = CMD_REF;
          RCW_PR:  w_cmd = bus.a[10] ? CMD_PRA : CMD_PR;
          RCW_RSV: w_cmd = CMD_RSV;
          RCW_WR:  w_cmd = bus.a[10] ? CMD_WRA : CMD_WR;
          RCW_RD:  w_cmd = bus.a[10] ? CMD_RDA : CMD_RD;
          RCW_BST: w_cmd = bus.a[10] ? CMD_CFG : CMD_BST;
          default: w_cmd = CMD_NOP;
        endcase
      end
    end
  end

  // Power FSM next state and next-cycle strobes
  always_comb begin
    w_state_nxt = r_state;
    w_strb      = '0;
    w_err       = 1'b0;
    w_all_sel   = 1'b0;
    w_clear_all = 1'b0;
    case (r_state)
      PWR_INIT: begin
        if (w_rise) begin
          w_strb.ckeh = 1'b1;
          w_all_sel   = 1'b1;
          w_state_nxt = PWR_ACTIVE;
        end
      end
      PWR_ACTIVE: begin
        if (bus.cke) begin
          if (w_legal) w_strb = cmd_strobe(w_cmd);
          w_err = (w_cmd != CMD_NOP) && !w_legal;
        end else begin
          // cke fall: the sampled command selects the low-power state
          w_strb.ckel = 1'b1;
          w_all_sel   = 1'b1;
          w_state_nxt = PWR_PWRDN;
          case (w_cmd)
            CMD_REF: begin
              if (w_any_open) begin
                w_err     = 1'b1;
                w_strb.pd = 1'b1;
              end else begin
                w_strb.srf  = 1'b1;
                w_state_nxt = PWR_SELFREF;
              end
            end
            CMD_BST: begin
              w_strb.dpd  = 1'b1;
              w_state_nxt = PWR_DEEPPD;
            end
            CMD_NOP: w_strb.pd = 1'b1;
            default: begin
              w_err     = 1'b1;
              w_strb.pd = 1'b1;
            end
          endcase
        end
      end
      PWR_PWRDN, PWR_SELFREF, PWR_DEEPPD: begin
        w_err = (w_cmd != CMD_NOP);
        if (w_rise) begin
          w_strb.ckeh = 1'b1;
          w_all_sel   = 1'b1;
          w_state_nxt = PWR_ACTIVE;
          if (r_state == PWR_PWRDN) w_strb.pdx = 1'b1;
          if (r_state == PWR_DEEPPD) begin
            w_strb.dpdx = 1'b1;
            w_clear_all = 1'b1;
          end
        end
      end
      default: w_state_nxt = PWR_INIT;
    endcase
  end

  memcmd_bank_tracker #(
    .NBANK (NBANK),
    .BIDX  (BIDX)
  ) u_bank_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd       (w_trk_cmd),
    .i_idx       (w_idx),
    .i_all_sel   (w_all_sel),
    .i_clear_all (w_clear_all),
    .o_legal     (w_legal),
    .o_any_open  (w_any_open),
    .o_bank_sel  (w_bank_sel),
    .o_bank_open (w_bank_open)
  );

  // State register and output pipeline stage
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state    <= PWR_INIT;
      r_cke_q    <= 1'b0;
      r_strb     <= '0;
      r_err      <= 1'b0;
      r_bank_sel <= '0;
      r_bank_idx <= '0;
      r_row_addr <= '0;
      r_col_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cke_q    <= bus.cke;
      r_strb     <= w_strb;
      r_err      <= w_err;
      r_bank_sel <= w_bank_sel;
      if (w_fwd && is_banked(w_trk_cmd)) r_bank_idx <= w_idx;
      if (w_fwd && w_trk_cmd == CMD_ACT) r_row_addr <= bus.a;
      if (w_fwd && w_trk_cmd inside {CMD_RD, CMD_RDA, CMD_WR, CMD_WRA})
        r_col_addr <= bus.a[9:0];
    end
  end

  assign bus.ACT  = r_strb.act;
  assign bus.RD   = r_strb.rd;
  assign bus.RDA  = r_strb.rda;
  assign bus.WR   = r_strb.wr;
  assign bus.WRA  = r_strb.wra;
  assign bus.PR   = r_strb.pr;
  assign bus.PRA  = r_strb.pra;
  assign bus.REF  = r_strb.refr;
  assign bus.SRF  = r_strb.srf;
  assign bus.PD   = r_strb.pd;
  assign bus.PDX  = r_strb.pdx;
  assign bus.DPD  = r_strb.dpd;
  assign bus.DPDX = r_strb.dpdx;
  assign bus.MRW  = r_strb.mrw;
  assign bus.MRR  = r_strb.mrr;
  assign bus.BST  = r_strb.bst;
  assign bus.CFG  = r_strb.cfg;
  assign bus.CKEH = r_strb.ckeh;
  assign bus.CKEL = r_strb.ckel;

  assign bus.bank_sel  = r_bank_sel;
  assign bus.bank_idx  = r_bank_idx;
  assign bus.row_addr  = r_row_addr;
  assign bus.col_addr  = r_col_addr;
  assign bus.bank_open = w_bank_open;
  assign bus.cmd_err   = r_err;

endmodule

// File: tb/tb_memcmd_decode.sv
// Scoreboard bench for memcmd_decode: each directed vector pushes its
// hand-computed response; a monitor pops and compares one per cycle.
module tb_memcmd_decode;
  import memcmd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memcmd_if #(.NBG(2), .NBA(4), .ADDRW(17)) bus ();

  memcmd_decode #(.NBG(2), .NBA(4), .ADDRW(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {cs_n, act_n, ras_n, cas_n, we_n}
  localparam logic [4:0] P_NOP = 5'b01111;
  localparam logic [4:0] P_DES = 5'b11111;
  localparam logic [4:0] P_ACT = 5'b00111;
  localparam logic [4:0] P_RD  = 5'b01101;
  localparam logic [4:0] P_WR  = 5'b01100;
  localparam logic [4:0] P_PR  = 5'b01010;
  localparam logic [4:0] P_REF = 5'b01001;
  localparam logic [4:0] P_MRW = 5'b01000;
  localparam logic [4:0] P_BST = 5'b01110;
  localparam logic [4:0] P_RSV = 5'b01011;

  typedef enum {T_NONE, T_ACT, T_RD, T_RDA, T_WR, T_WRA, T_PR, T_PRA, T_REF, T_SRF,
                T_PD, T_PDX, T_DPD, T_DPDX, T_MRW, T_MRR, T_BST, T_CFG, T_CKEH, T_CKEL} st_e;

  typedef struct {
    string       nm;
    strobe_t     strb;
    logic [7:0]  sel;
    logic        err;
    logic [2:0]  idx;
    logic [16:0] row;
    logic [9:0]  col;
    logic [7:0]  open;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected holding registers, updated by hand in the stimulus sequence
  logic [2:0]  e_idx  = '0;
  logic [16:0] e_row  = '0;
  logic [9:0]  e_col  = '0;
  logic [7:0]  e_open = '0;

  strobe_t a_strb;
  always_comb begin
    a_strb.act  = bus.ACT;  a_strb.rd   = bus.RD;   a_strb.rda  = bus.RDA;
    a_strb.wr   = bus.WR;   a_strb.wra  = bus.WRA;  a_strb.pr   = bus.PR;
    a_strb.pra  = bus.PRA;  a_strb.refr = bus.REF;  a_strb.srf  = bus.SRF;
    a_strb.pd   = bus.PD;   a_strb.pdx  = bus.PDX;  a_strb.dpd  = bus.DPD;
    a_strb.dpdx = bus.DPDX; a_strb.mrw  = bus.MRW;  a_strb.mrr  = bus.MRR;
    a_strb.bst  = bus.BST;  a_strb.cfg  = bus.CFG;  a_strb.ckeh = bus.CKEH;
    a_strb.ckel = bus.CKEL;
  end

  function automatic strobe_t set1(input strobe_t s_in, input st_e t);
    strobe_t s;
    s = s_in;
    case (t)
      T_ACT:  s.act  = 1'b1;  T_RD:   s.rd   = 1'b1;  T_RDA:  s.rda  = 1'b1;
      T_WR:   s.wr   = 1'b1;  T_WRA:  s.wra  = 1'b1;  T_PR:   s.pr   = 1'b1;
      T_PRA:  s.pra  = 1'b1;  T_REF:  s.refr = 1'b1;  T_SRF:  s.srf  = 1'b1;
      T_PD:   s.pd   = 1'b1;  T_PDX:  s.pdx  = 1'b1;  T_DPD:  s.dpd  = 1'b1;
      T_DPDX: s.dpdx = 1'b1;  T_MRW:  s.mrw  = 1'b1;  T_MRR:  s.mrr  = 1'b1;
      T_BST:  s.bst  = 1'b1;  T_CFG:  s.cfg  = 1'b1;  T_CKEH: s.ckeh = 1'b1;
      T_CKEL: s.ckel = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  function automatic strobe_t mk(input st_e t1, input st_e t2 = T_NONE);
    strobe_t s;
    s = '0;
    s = set1(s, t1);
    s = set1(s, t2);
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " strobes"},   32'(a_strb),        32'h0);
    check({nm, " bank_sel"},  32'(bus.bank_sel),  32'h0);
    check({nm, " cmd_err"},   32'(bus.cmd_err),   32'h0);
    check({nm, " bank_idx"},  32'(bus.bank_idx),  32'h0);
    check({nm, " row_addr"},  32'(bus.row_addr),  32'h0);
    check({nm, " col_addr"},  32'(bus.col_addr),  32'h0);
    check({nm, " bank_open"}, 32'(bus.bank_open), 32'h0);
  endtask

  // Drive one command for one cycle and queue its expected response
  task automatic step(input string nm, input logic cke_v, input logic [4:0] pins,
                      input logic [2:0] bank, input logic [16:0] a_v,
                      input strobe_t e_strb, input logic [7:0] e_sel, input logic e_err);
    exp_t e;
    bus.cke = cke_v;
    {bus.cs_n, bus.act_n, bus.ras_n, bus.cas_n, bus.we_n} = pins;
    bus.bg = bank[2];
    bus.ba = bank[1:0];
    bus.a  = a_v;
    @(posedge clk);
    #1;
    e.nm = nm; e.strb = e_strb; e.sel = e_sel; e.err = e_err;
    e.idx = e_idx; e.row = e_row; e.col = e_col; e.open = e_open;
    exp_q.push_back(e);
  endtask

  // Monitor: compare one queued response per cycle, away from the edge
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.nm, " strobes"},   32'(a_strb),        32'(e.strb));
        check({e.nm, " bank_sel"},  32'(bus.bank_sel),  32'(e.sel));
        check({e.nm, " cmd_err"},   32'(bus.cmd_err),   32'(e.err));
        check({e.nm, " bank_idx"},  32'(bus.bank_idx),  32'(e.idx));
        check({e.nm, " row_addr"},  32'(bus.row_addr),  32'(e.row));
        check({e.nm, " col_addr"},  32'(bus.col_addr),  32'(e.col));
        check({e.nm, " bank_open"}, 32'(bus.bank_open), 32'(e.open));
      end else if (rst_n && (a_strb != '0 || bus.cmd_err || bus.bank_sel != '0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL idle_activity: strobes 0x%0h bank_sel 0x%0h cmd_err %0b, expected all 0",
                 a_strb, bus.bank_sel, bus.cmd_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cke = 1'b0;
    {bus.cs_n, bus.act_n, bus.ras_n, bus.cas_n, bus.we_n} = P_DES;
    bus.bg = '0; bus.ba = '0; bus.a = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Power-up and basic bank traffic
    step("cke_rise",     1'b1, P_NOP, 3'd0, 17'h0,    mk(T_CKEH), 8'hFF, 1'b0);
    step("nop",          1'b1, P_NOP, 3'd0, 17'h0,    mk(T_NONE), 8'h00, 1'b0);
    e_idx = 3'd6; e_row = 17'h1234; e_open = 8'h40;
    step("act_b6",       1'b1, P_ACT, 3'd6, 17'h1234, mk(T_ACT),  8'h40, 1'b0);
    e_col = 10'h03F; e_open = 8'h00;
    step("rda_b6",       1'b1, P_RD,  3'd6, 17'h043F, mk(T_RDA),  8'h40, 1'b0);
    step("rd_closed",    1'b1, P_RD,  3'd3, 17'h0005, mk(T_NONE), 8'h00, 1'b1);
    e_row = 17'h0100; e_open = 8'h40;
    step("act_b6_again", 1'b1, P_ACT, 3'd6, 17'h0100, mk(T_ACT),  8'h40, 1'b0);
    step("act_open",     1'b1, P_ACT, 3'd6, 17'h0222, mk(T_NONE), 8'h00, 1'b1);
    e_col = 10'h011;
    step("wr_b6",        1'b1, P_WR,  3'd6, 17'h0011, mk(T_WR),   8'h40, 1'b0);
    step("ref_open",     1'b1, P_REF, 3'd0, 17'h0,    mk(T_NONE), 8'h00, 1'b1);
    e_idx = 3'd1;
    step("pr_closed",    1'b1, P_PR,  3'd1, 17'h0,    mk(T_PR),   8'h02, 1'b0);
    e_open = 8'h00;
    step("pra",          1'b1, P_PR,  3'd0, 17'h0400, mk(T_PRA),  8'hFF, 1'b0);
    step("rsv",          1'b1, P_RSV, 3'd0, 17'h0,    mk(T_NONE), 8'h00, 1'b1);
    step("mrr",          1'b1, P_MRW, 3'd0, 17'h2000, mk(T_MRR),  8'hFF, 1'b0);
    step("cfg",          1'b1, P_BST, 3'd0, 17'h0400, mk(T_CFG),  8'hFF, 1'b0);
    step("ref",          1'b1, P_REF, 3'd0, 17'h0,    mk(T_REF),  8'hFF, 1'b0);

    // Self-refresh and deep power-down round trips
    step("srf_entry",    1'b0, P_REF, 3'd0, 17'h0,    mk(T_CKEL, T_SRF),  8'hFF, 1'b0);
    step("in_selfref",   1'b0, P_DES, 3'd0, 17'h0,    mk(T_NONE),         8'h00, 1'b0);
    step("srf_exit",     1'b1, P_NOP, 3'd0, 17'h0,    mk(T_CKEH),         8'hFF, 1'b0);
    step("dpd_entry",    1'b0, P_BST, 3'd0, 17'h0,    mk(T_CKEL, T_DPD),  8'hFF, 1'b0);
    step("in_deeppd",    1'b0, P_DES, 3'd0, 17'h0,    mk(T_NONE),         8'h00, 1'b0);
    step("dpd_exit",     1'b1, P_DES, 3'd0, 17'h0,    mk(T_CKEH, T_DPDX), 8'hFF, 1'b0);

    // Power-down entry with a command pending
    e_idx = 3'd0; e_row = 17'h1; e_open = 8'h01;
    step("act_b0",       1'b1, P_ACT, 3'd0, 17'h1,    mk(T_ACT),  8'h01, 1'b0);
    e_idx = 3'd1; e_row = 17'h2; e_open = 8'h03;
    step("act_b1",       1'b1, P_ACT, 3'd1, 17'h2,    mk(T_ACT),  8'h02, 1'b0);
    step("pd_wr_pending",1'b0, P_WR,  3'd0, 17'h0007, mk(T_CKEL, T_PD),  8'hFF, 1'b1);
    step("cmd_in_pwrdn", 1'b0, P_RD,  3'd0, 17'h0,    mk(T_NONE),        8'h00, 1'b1);
    step("pd_exit",      1'b1, P_NOP, 3'd0, 17'h0,    mk(T_CKEH, T_PDX), 8'hFF, 1'b0);
    e_idx = 3'd7; e_row = 17'h3; e_open = 8'h83;
    step("act_b7",       1'b1, P_ACT, 3'd7, 17'h3,    mk(T_ACT),  8'h80, 1'b0);

    // Asynchronous reset with three banks open
    @(negedge clk);
    #2;
    bus.cke = 1'b0;
    {bus.cs_n, bus.act_n, bus.ras_n, bus.cas_n, bus.we_n} = P_DES;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    e_idx = '0; e_row = '0; e_col = '0; e_open = '0;
    step("init_ignores",   1'b0, P_ACT, 3'd5, 17'h0055, mk(T_NONE), 8'h00, 1'b0);
    step("init_rise",      1'b1, P_NOP, 3'd0, 17'h0,    mk(T_CKEH), 8'hFF, 1'b0);
    step("rd_after_reset", 1'b1, P_RD,  3'd7, 17'h0,    mk(T_NONE), 8'h00, 1'b1);
    step("idle",           1'b1, P_NOP, 3'd0, 17'h0,    mk(T_NONE), 8'h00, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses never compared, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
